// File: rtl/mem_stage_pkg.sv
//============================================================================
// Module   : mem_stage_pkg
// Brief    : Shared bus widths and execute->memory payload layout.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package mem_stage_pkg;

    localparam int c_ES_TO_MS_BUS_WD = 80;
    localparam int c_MS_TO_WS_BUS_WD = 72;
    localparam int c_MS_TO_DS_BUS_WD = 40;

    // Field order is MSB first and must track the execute-stage packing.
    typedef struct packed {
        logic        ertn;
        logic        ex;
        logic        mem_access;
        logic [1:0]  addr_lo;
        logic        ld_hu;
        logic        ld_bu;
        logic        ld_h;
        logic        ld_b;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] es_result;
        logic [31:0] pc;
    } es_to_ms_t;

    function automatic logic is_load(input es_to_ms_t p);
        return p.res_from_mem | p.ld_b | p.ld_h | p.ld_bu | p.ld_hu;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
//============================================================================
// Module   : load_align
// Brief    : Byte/half selection and sign/zero extension of load data.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic        ld_b,
    input  logic        ld_h,
    input  logic        ld_bu,
    input  logic        ld_hu,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr_lo)
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            2'd3:    w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        // Word loads fall through to the raw data.
        if (ld_b) begin
            result = {{24{w_byte[7]}}, w_byte};
        end else if (ld_bu) begin
            result = {24'd0, w_byte};
        end else if (ld_h) begin
            result = {{16{w_half[15]}}, w_half};
        end else if (ld_hu) begin
            result = {16'd0, w_half};
        end else begin
            result = rdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
//============================================================================
// Module   : mem_stage
// Brief    : Memory-access pipeline stage: waits for data_ok, holds read
//            data across writeback stalls, aligns loads, absorbs orphans.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ws_allowin,
    output logic                         ms_allowin,
    input  logic                         es_to_ms_valid,
    input  logic [c_ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                         ms_to_ws_valid,
    output logic [c_MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                         data_ok,
    input  logic [31:0]                  data_sram_rdata,
    input  logic                         ws_flush,
    output logic                         ms_to_es_bus,
    output logic [c_MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;
    localparam logic [1:0] c_DROP = 2'd3;

    logic        r_ms_valid;
    es_to_ms_t   r_payload;
    logic [1:0]  r_state;
    logic [31:0] r_rdata_buf;

    es_to_ms_t   w_in;
    logic [1:0]  w_state_nxt;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_enter_wait;
    logic        w_is_load;
    logic [31:0] w_load_data;
    logic [31:0] w_aligned;
    logic [31:0] w_final;
    logic        w_load_pending;

    assign w_in = es_to_ms_bus;

    assign w_ready_go = !r_payload.mem_access || r_payload.ex
                     || (r_state == c_WAIT && data_ok)
                     || (r_state == c_HOLD);

    // DROP owns the SRAM response channel, so nothing new may enter.
    assign ms_allowin   = (r_state != c_DROP)
                       && (!r_ms_valid || (w_ready_go && ws_allowin));
    assign w_accept     = es_to_ms_valid && ms_allowin && !ws_flush;
    assign w_enter_wait = w_accept && w_in.mem_access && !w_in.ex;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_enter_wait) begin
                    w_state_nxt = c_WAIT;
                end
            end
            c_WAIT: begin
                if (data_ok) begin
                    if (ws_flush || ws_allowin) begin
                        w_state_nxt = w_enter_wait ? c_WAIT : c_IDLE;
                    end else begin
                        w_state_nxt = c_HOLD;
                    end
                end else if (ws_flush) begin
                    w_state_nxt = c_DROP;
                end
            end
            c_HOLD: begin
                if (ws_flush || ws_allowin) begin
                    w_state_nxt = w_enter_wait ? c_WAIT : c_IDLE;
                end
            end
            c_DROP: begin
                if (data_ok) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid  <= 1'b0;
            r_state     <= c_IDLE;
            r_rdata_buf <= 32'd0;
            r_payload   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (ws_flush) begin
                r_ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (w_accept) begin
                r_payload <= w_in;
            end
            if (r_state == c_WAIT && data_ok && !ws_allowin && !ws_flush) begin
                r_rdata_buf <= data_sram_rdata;
            end
        end
    end

    assign w_load_data = data_ok ? data_sram_rdata : r_rdata_buf;

    load_align u_load_align (
        .rdata   (w_load_data),
        .addr_lo (r_payload.addr_lo),
        .ld_b    (r_payload.ld_b),
        .ld_h    (r_payload.ld_h),
        .ld_bu   (r_payload.ld_bu),
        .ld_hu   (r_payload.ld_hu),
        .result  (w_aligned)
    );

    assign w_is_load      = is_load(r_payload);
    assign w_final        = w_is_load ? w_aligned : r_payload.es_result;
    assign w_load_pending = r_ms_valid && w_is_load && !w_ready_go;

    assign ms_to_ws_valid = r_ms_valid && w_ready_go;
    assign ms_to_ws_bus   = {r_payload.ertn, r_payload.ex, r_payload.gr_we,
                             r_payload.dest, w_final, r_payload.pc};
    assign ms_to_es_bus   = r_ms_valid && (r_payload.ex || r_payload.ertn);
    assign ms_to_ds_bus   = {r_ms_valid, r_payload.gr_we, w_load_pending,
                             r_payload.dest, w_final};

`ifndef SYNTHESIS
    // A response is only legal while a request is outstanding.
    a_data_ok_outstanding: assert property (
        @(posedge clk) disable iff (!resetn)
        data_ok |-> (r_state == c_WAIT || r_state == c_DROP)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//============================================================================
// Module   : tb_mem_stage
// Brief    : Directed and randomized self-checking bench for mem_stage.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [79:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [71:0] ms_to_ws_bus;
    logic        data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_flush;
    logic        ms_to_es_bus;
    logic [39:0] ms_to_ds_bus;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_ok         (data_ok),
        .data_sram_rdata (data_sram_rdata),
        .ws_flush        (ws_flush),
        .ms_to_es_bus    (ms_to_es_bus),
        .ms_to_ds_bus    (ms_to_ds_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ops: 0 alu, 1 ld.w, 2 ld.b, 3 ld.h, 4 ld.bu, 5 ld.hu, 6 store, 7 ex, 8 ertn
    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] mk_bus(input int op, input logic [31:0] pc,
                                           input logic [31:0] res, input logic [4:0] dest,
                                           input logic [1:0] alo);
        logic [79:0] b;
        b         = '0;
        b[31:0]   = pc;
        b[63:32]  = res;
        b[68:64]  = dest;
        b[69]     = (op <= 5);
        b[70]     = (op == 1);
        b[71]     = (op == 2);
        b[72]     = (op == 3);
        b[73]     = (op == 4);
        b[74]     = (op == 5);
        b[76:75]  = alo;
        b[77]     = (op >= 1 && op <= 6);
        b[78]     = (op == 7);
        b[79]     = (op == 8);
        return b;
    endfunction

    function automatic logic [31:0] model_result(input int op, input logic [1:0] alo,
                                                 input logic [31:0] res, input logic [31:0] rd);
        logic [31:0] v;
        case (op)
            1: v = rd;
            2, 4: begin
                v = (rd >> (8 * int'(alo))) & 32'hFF;
                if (op == 2 && v >= 32'd128) v = v - 32'd256;
            end
            3, 5: begin
                v = (rd >> (16 * int'(alo[1]))) & 32'hFFFF;
                if (op == 3 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = res;
        endcase
        return v;
    endfunction

    function automatic logic [71:0] exp_ws(input int op, input logic [31:0] pc,
                                           input logic [4:0] dest, input logic [31:0] fin);
        logic gr_we;
        gr_we = (op <= 5);
        return {(op == 8), (op == 7), gr_we, dest, fin, pc};
    endfunction

    task automatic gen_txn(output int op, output logic [31:0] pc, output logic [31:0] res,
                           output logic [4:0] dest, output logic [1:0] alo);
        op   = int'($urandom_range(0, 8));
        pc   = $urandom & 32'hFFFF_FFFC;
        res  = $urandom;
        dest = 5'($urandom_range(0, 31));
        alo  = (op >= 1 && op <= 6) ? res[1:0] : 2'($urandom_range(0, 3));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_allowin"},  80'(ms_allowin),     80'(1));
        chk({tag, "_ws_valid"}, 80'(ms_to_ws_valid), 80'(0));
        chk({tag, "_es_bus"},   80'(ms_to_es_bus),   80'(0));
        chk({tag, "_ds_bus"},   80'(ms_to_ds_bus),   80'(0));
        chk({tag, "_ws_bus"},   80'(ms_to_ws_bus),   80'(0));
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int          op, nop, lat, stall;
        logic [31:0] pc, res, rd, npc, nres;
        logic [4:0]  dst, ndst;
        logic [1:0]  alo, nalo;
        logic [71:0] exp;
        logic        is_ld, is_mem, back, exp_es;

        resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_ok = 1'b0; data_sram_rdata = '0; ws_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        tick();

        // ALU op: one cycle in stage.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(0, 32'h1c00_0000, 32'h1234_5678, 5'd5, 2'd0);
        #1 chk("alu_allowin", 80'(ms_allowin), 80'(1));
        tick();
        es_to_ms_valid = 1'b0;
        #1 chk("alu_ws_valid", 80'(ms_to_ws_valid), 80'(1));
        chk("alu_ws_bus", 80'(ms_to_ws_bus), 80'(exp_ws(0, 32'h1c00_0000, 5'd5, 32'h1234_5678)));
        tick();
        #1 chk("alu_drain", 80'(ms_to_ws_valid), 80'(0));

        // ld.b addr_lo=3, data_ok two cycles after accept.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(2, 32'h1c00_0004, 32'h1000_0003, 5'd7, 2'd3);
        tick();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_ok = 1'b0;
            #1 chk("ldb_pending", 80'(ms_to_ds_bus[37]), 80'(1));
            chk("ldb_wait_valid", 80'(ms_to_ws_valid), 80'(0));
            tick();
        end
        data_ok = 1'b1; data_sram_rdata = 32'h80FF_0000;
        #1 chk("ldb_ws_valid", 80'(ms_to_ws_valid), 80'(1));
        chk("ldb_result", 80'(ms_to_ws_bus[63:32]), 80'(32'hFFFF_FF80));
        chk("ldb_pending_clr", 80'(ms_to_ds_bus[37]), 80'(0));
        tick();
        data_ok = 1'b0;

        // ld.hu addr_lo=2 with writeback stalled three cycles.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(5, 32'h1c00_0008, 32'h2000_0002, 5'd9, 2'd2);
        tick();
        es_to_ms_valid = 1'b0;
        data_ok = 1'b1; data_sram_rdata = 32'h8001_1234; ws_allowin = 1'b0;
        #1 chk("ldhu_ws_valid", 80'(ms_to_ws_valid), 80'(1));
        tick();
        data_ok = 1'b0; data_sram_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 2; i++) begin
            #1 chk("ldhu_hold_result", 80'(ms_to_ws_bus[63:32]), 80'(32'h0000_8001));
            chk("ldhu_hold_allowin", 80'(ms_allowin), 80'(0));
            tick();
        end
        ws_allowin = 1'b1;
        #1 chk("ldhu_release", 80'(ms_to_ws_bus), 80'(exp_ws(5, 32'h1c00_0008, 5'd9, 32'h0000_8001)));
        tick();
        #1 chk("ldhu_drain", 80'(ms_to_ws_valid), 80'(0));

        // Flush in WAIT, then an orphaned data_ok is absorbed.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(1, 32'h1c00_000c, 32'h3000_0000, 5'd3, 2'd0);
        tick();
        es_to_ms_valid = 1'b0; ws_flush = 1'b1;
        tick();
        ws_flush = 1'b0; es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(0, 32'h1c00_0010, 32'h0000_0042, 5'd4, 2'd0);
        #1 chk("drop_ms_valid", 80'(ms_to_ds_bus[39]), 80'(0));
        chk("drop_allowin", 80'(ms_allowin), 80'(0));
        tick();
        data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        #1 chk("drop_orphan_valid", 80'(ms_to_ws_valid), 80'(0));
        chk("drop_orphan_allowin", 80'(ms_allowin), 80'(0));
        tick();
        data_ok = 1'b0; es_to_ms_valid = 1'b0;
        #1 chk("drop_exit_allowin", 80'(ms_allowin), 80'(1));
        chk("drop_no_accept", 80'(ms_to_ds_bus[39]), 80'(0));

        // Accept coinciding with flush is ignored.
        es_to_ms_valid = 1'b1; ws_flush = 1'b1;
        tick();
        es_to_ms_valid = 1'b0; ws_flush = 1'b0;
        #1 chk("flush_accept_ignored", 80'(ms_to_ws_valid), 80'(0));

        // Exception passes without waiting.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(7, 32'h1c00_0014, 32'h0000_0099, 5'd0, 2'd0);
        tick();
        es_to_ms_valid = 1'b0;
        #1 chk("ex_es_bus", 80'(ms_to_es_bus), 80'(1));
        chk("ex_ws_bus", 80'(ms_to_ws_bus), 80'(exp_ws(7, 32'h1c00_0014, 5'd0, 32'h0000_0099)));
        tick();
        #1 chk("ex_es_bus_clr", 80'(ms_to_es_bus), 80'(0));

        // Asynchronous reset while in HOLD.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(1, 32'h1c00_0018, 32'h4000_0000, 5'd6, 2'd0);
        tick();
        es_to_ms_valid = 1'b0; data_ok = 1'b1; data_sram_rdata = 32'h1111_2222; ws_allowin = 1'b0;
        tick();
        data_ok = 1'b0;
        #2 resetn = 1'b0;
        #1 check_reset_outputs("hold_reset");
        tick();
        resetn = 1'b1; ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(1, 32'h1c00_001c, 32'h5000_0000, 5'd8, 2'd0);
        tick();
        es_to_ms_valid = 1'b0; data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
        #1 chk("post_reset_ld", 80'(ms_to_ws_bus), 80'(exp_ws(1, 32'h1c00_001c, 5'd8, 32'hCAFE_F00D)));
        tick();
        data_ok = 1'b0;
        #1 chk("post_reset_drain", 80'(ms_to_ws_valid), 80'(0));

        // Randomized traffic with back-to-back and bubbled issue.
        gen_txn(op, pc, res, dst, alo);
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk_bus(op, pc, res, dst, alo);
        #1 chk("rnd_first_allowin", 80'(ms_allowin), 80'(1));
        tick();
        es_to_ms_valid = 1'b0;
        for (int t = 0; t < 200; t++) begin
            is_mem = (op >= 1 && op <= 6);
            is_ld  = (op >= 1 && op <= 5);
            rd     = $urandom;
            if (is_mem) begin
                lat = int'($urandom_range(0, 3));
                repeat (lat) begin
                    data_ok = 1'b0; ws_allowin = 1'($urandom_range(0, 1));
                    #1 chk("rnd_pending", 80'(ms_to_ds_bus[37]), 80'(is_ld));
                    chk("rnd_wait_valid", 80'(ms_to_ws_valid), 80'(0));
                    tick();
                end
                data_ok = 1'b1; data_sram_rdata = rd;
            end
            exp    = exp_ws(op, pc, dst, model_result(op, alo, res, rd));
            exp_es = (op >= 7);
            stall  = int'($urandom_range(0, 2));
            repeat (stall) begin
                ws_allowin = 1'b0;
                #1 chk("rnd_stall_bus", 80'(ms_to_ws_bus), 80'(exp));
                chk("rnd_stall_valid", 80'(ms_to_ws_valid), 80'(1));
                tick();
                data_ok = 1'b0; data_sram_rdata = $urandom;
            end
            ws_allowin = 1'b1;
            back = 1'($urandom_range(0, 1));
            if (back) begin
                gen_txn(nop, npc, nres, ndst, nalo);
                es_to_ms_valid = 1'b1; es_to_ms_bus = mk_bus(nop, npc, nres, ndst, nalo);
            end
            #1 chk("rnd_leave_bus", 80'(ms_to_ws_bus), 80'(exp));
            chk("rnd_leave_valid", 80'(ms_to_ws_valid), 80'(1));
            chk("rnd_es_bus", 80'(ms_to_es_bus), 80'(exp_es));
            chk("rnd_leave_allowin", 80'(ms_allowin), 80'(1));
            tick();
            data_ok = 1'b0; es_to_ms_valid = 1'b0;
            if (!back) begin
                #1 chk("rnd_bubble_valid", 80'(ms_to_ds_bus[39]), 80'(0));
                gen_txn(nop, npc, nres, ndst, nalo);
                es_to_ms_valid = 1'b1; es_to_ms_bus = mk_bus(nop, npc, nres, ndst, nalo);
                tick();
                es_to_ms_valid = 1'b0;
            end
            op = nop; pc = npc; res = nres; dst = ndst; alo = nalo;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
